// File: rtl/hit_scorer_pkg.sv
// Shared types and point values for the hit_scorer judging pipeline.
package gv_pkg;

    typedef enum logic [1:0] {
        J_NONE    = 2'd0,
        J_GOOD    = 2'd1,
        J_PERFECT = 2'd2,
        J_MISS    = 2'd3
    } judge_t;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_OPEN = 1'b1
    } lane_state_t;

    localparam int unsigned PTS_GOOD    = 32'd1;
    localparam int unsigned PTS_PERFECT = 32'd3;

    function automatic int unsigned judge_points(input judge_t j);
        int unsigned pts;
        case (j)
            J_PERFECT: pts = PTS_PERFECT;
            J_GOOD:    pts = PTS_GOOD;
            default:   pts = 32'd0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/hit_scorer_lane.sv
// hit_lane: one lane's IDLE/OPEN window tracker; emits a combinational judgement each cycle.
module hit_lane
    import gv_pkg::*;
#(
    parameter int WINDOW       = 8,
    parameter int PERFECT_ZONE = 2
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   strike,
    input  logic   note_arrive,
    output judge_t judge
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W:0]   PZ_LIMIT = (CNT_W + 1)'(PERFECT_ZONE);

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Lane state and window-count register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= L_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The arrival cycle itself is count 0, so an opening window registers count 1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        judge   = J_NONE;
        case (state_q)
            L_IDLE: begin
                if (strike) begin
                    judge = note_arrive ? J_PERFECT : J_MISS;
                end else if (note_arrive) begin
                    state_d = L_OPEN;
                    count_d = CNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            L_OPEN: begin
                if (strike) begin
                    judge = ({1'b0, count_q} < PZ_LIMIT) ? J_PERFECT : J_GOOD;
                    if (note_arrive) begin
                        count_d = CNT_ONE;
                    end else begin
                        state_d = L_IDLE;
                        count_d = '0;
                    end
                end else if (note_arrive) begin
                    judge   = J_MISS;
                    count_d = CNT_ONE;
                end else if (count_q == CNT_LAST) begin
                    judge   = J_MISS;
                    state_d = L_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = L_IDLE;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/hit_scorer.sv
// hit_scorer: per-lane judging, registered judgement pulses, saturating score/combo.
// Optional macro HIT_SCORER_COMBO_BONUS_EN doubles a cycle's points at combo >= COMBO_BONUS.
module hit_scorer
    import gv_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int WINDOW       = 8,
    parameter int PERFECT_ZONE = 2,
    parameter int SCORE_W      = 14,
    parameter int COMBO_W      = 7,
    parameter int COMBO_BONUS  = 10
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [LANES-1:0]   strike,
    input  logic [LANES-1:0]   note_arrive,
    input  logic               clear,
    output logic [LANES-1:0]   hit,
    output logic [LANES-1:0]   perfect,
    output logic [LANES-1:0]   miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

`ifdef HIT_SCORER_COMBO_BONUS_EN
    localparam logic BONUS_ENABLE = 1'b1;
`else
    localparam logic BONUS_ENABLE = 1'b0;
`endif

    localparam int SUM_W = $clog2(2 * PTS_PERFECT * LANES + 1);
    localparam int EXT_W = SCORE_W + SUM_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};
    localparam logic [COMBO_W:0]   BONUS_AT  = (COMBO_W + 1)'(COMBO_BONUS);

    judge_t lane_judge [LANES];

    logic [LANES-1:0]   hit_q, hit_d, perfect_q, perfect_d, miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d, max_combo_q, max_combo_d;
    logic [SUM_W-1:0]   pts_sum_s, pts_total_s;
    logic [EXT_W-1:0]   score_ext_s;
    logic [COMBO_W-1:0] combo_next_s;
    logic               bonus_active_s;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        hit_lane #(
            .WINDOW       (WINDOW),
            .PERFECT_ZONE (PERFECT_ZONE)
        ) u_lane (
            .clk         (clk),
            .n_rst       (n_rst),
            .strike      (strike[l]),
            .note_arrive (note_arrive[l]),
            .judge       (lane_judge[l])
        );
    end

    // Stage 1: decode lane judgements into pulse vectors.
    always_comb begin
        hit_d     = '0;
        perfect_d = '0;
        miss_d    = '0;
        for (int l = 0; l < LANES; l++) begin
            hit_d[l]     = (lane_judge[l] == J_GOOD) || (lane_judge[l] == J_PERFECT);
            perfect_d[l] = (lane_judge[l] == J_PERFECT);
            miss_d[l]    = (lane_judge[l] == J_MISS);
        end
    end

    // Stage 2: sum points from the registered pulses and saturate score/combo.
    always_comb begin
        pts_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            if (perfect_q[l]) begin
                pts_sum_s = pts_sum_s + SUM_W'(PTS_PERFECT);
            end else if (hit_q[l]) begin
                pts_sum_s = pts_sum_s + SUM_W'(PTS_GOOD);
            end else begin
                pts_sum_s = pts_sum_s;
            end
        end

        // Bonus looks at the combo before this cycle's update.
        bonus_active_s = BONUS_ENABLE && ({1'b0, combo_q} >= BONUS_AT);
        if (bonus_active_s) begin
            pts_total_s = pts_sum_s << 1;
        end else begin
            pts_total_s = pts_sum_s;
        end

        score_ext_s = EXT_W'(score_q) + EXT_W'(pts_total_s);
        if (score_ext_s > EXT_W'(SCORE_MAX)) begin
            score_d = SCORE_MAX;
        end else begin
            score_d = score_ext_s[SCORE_W-1:0];
        end

        if (|miss_q) begin
            combo_next_s = '0;
        end else if (|hit_q) begin
            combo_next_s = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + COMBO_W'(1);
        end else begin
            combo_next_s = combo_q;
        end
        combo_d = combo_next_s;

        if (combo_next_s > max_combo_q) begin
            max_combo_d = combo_next_s;
        end else begin
            max_combo_d = max_combo_q;
        end

        if (clear) begin
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
        end else begin
            score_d     = score_d;
        end
    end

    // Pipeline registers: judgement pulses are not affected by clear.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hit_q       <= '0;
            perfect_q   <= '0;
            miss_q      <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            hit_q       <= hit_d;
            perfect_q   <= perfect_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign hit       = hit_q;
    assign perfect   = perfect_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;

endmodule

// File: tb/tb_hit_scorer.sv
// Scoreboard bench for hit_scorer: a timestamp-based lane model predicts each cycle's outputs.
module tb_hit_scorer;

    localparam int LANES  = 4;
    localparam int WINDOW = 8;
    localparam int PZONE  = 2;
    localparam int CBONUS = 10;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  strike, note_arrive;
    logic        clear;
    logic [3:0]  hit, perfect, miss;
    logic [13:0] score;
    logic [6:0]  combo, max_combo;
    logic [3:0]  hit_b, perfect_b, miss_b;
    logic [3:0]  score_b;
    logic [6:0]  combo_b, max_combo_b;

    hit_scorer u_dut (
        .clk(clk), .n_rst(n_rst), .strike(strike), .note_arrive(note_arrive), .clear(clear),
        .hit(hit), .perfect(perfect), .miss(miss),
        .score(score), .combo(combo), .max_combo(max_combo)
    );

    hit_scorer #(.SCORE_W(4)) u_dut_small (
        .clk(clk), .n_rst(n_rst), .strike(strike), .note_arrive(note_arrive), .clear(clear),
        .hit(hit_b), .perfect(perfect_b), .miss(miss_b),
        .score(score_b), .combo(combo_b), .max_combo(max_combo_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] h, p, m;
        int sc, sc4, cb, mx;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_n = 0;
    bit   open_m [LANES];
    int   arr_m  [LANES];
    logic [3:0] prev_h, prev_p, prev_m;
    int   sc_m, sc4_m, cb_m, mx_m;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", tag, obs, exp, step_n);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            open_m[l] = 1'b0;
            arr_m[l]  = 0;
        end
        prev_h = 4'd0; prev_p = 4'd0; prev_m = 4'd0;
        sc_m = 0; sc4_m = 0; cb_m = 0; mx_m = 0;
        q_exp.delete();
    endtask

    task automatic do_reset();
        n_rst = 1'b0; strike = 4'd0; note_arrive = 4'd0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hit", int'(hit), 0);
        check_val("rst_perfect", int'(perfect), 0);
        check_val("rst_miss", int'(miss), 0);
        check_val("rst_score", int'(score), 0);
        check_val("rst_combo", int'(combo), 0);
        check_val("rst_max_combo", int'(max_combo), 0);
        model_reset();
        n_rst = 1'b1;
    endtask

    // Drive one cycle of stimulus, predict the outputs after the edge, then compare.
    task automatic step(input logic [3:0] st, input logic [3:0] ar, input logic clr);
        exp_t e, got;
        int   pts, age;
        strike = st; note_arrive = ar; clear = clr;
        e.h = 4'd0; e.p = 4'd0; e.m = 4'd0;
        for (int l = 0; l < LANES; l++) begin
            if (open_m[l]) begin
                age = step_n - arr_m[l];
                if (st[l]) begin
                    e.h[l] = 1'b1;
                    e.p[l] = (age < PZONE);
                    open_m[l] = ar[l];
                    arr_m[l]  = step_n;
                end else if (ar[l]) begin
                    e.m[l] = 1'b1;
                    arr_m[l] = step_n;
                end else if (age == WINDOW - 1) begin
                    e.m[l] = 1'b1;
                    open_m[l] = 1'b0;
                end
            end else begin
                if (st[l] && ar[l]) begin
                    e.h[l] = 1'b1;
                    e.p[l] = 1'b1;
                end else if (st[l]) begin
                    e.m[l] = 1'b1;
                end else if (ar[l]) begin
                    open_m[l] = 1'b1;
                    arr_m[l]  = step_n;
                end
            end
        end
        pts = 0;
        for (int l = 0; l < LANES; l++) begin
            pts += prev_p[l] ? 3 : (prev_h[l] ? 1 : 0);
        end
`ifdef HIT_SCORER_COMBO_BONUS_EN
        if (cb_m >= CBONUS) pts = pts * 2;
`endif
        sc_m  = (sc_m + pts > 16383) ? 16383 : sc_m + pts;
        sc4_m = (sc4_m + pts > 15) ? 15 : sc4_m + pts;
        if (prev_m != 4'd0) cb_m = 0;
        else if (prev_h != 4'd0) cb_m = (cb_m == 127) ? 127 : cb_m + 1;
        if (cb_m > mx_m) mx_m = cb_m;
        if (clr) begin
            sc_m = 0; sc4_m = 0; cb_m = 0; mx_m = 0;
        end
        prev_h = e.h; prev_p = e.p; prev_m = e.m;
        e.sc = sc_m; e.sc4 = sc4_m; e.cb = cb_m; e.mx = mx_m;
        q_exp.push_back(e);

        @(posedge clk);
        #1;
        step_n++;
        got = q_exp.pop_front();
        check_val("hit", int'(hit), int'(got.h));
        check_val("perfect", int'(perfect), int'(got.p));
        check_val("miss", int'(miss), int'(got.m));
        check_val("score", int'(score), got.sc);
        check_val("score_small", int'(score_b), got.sc4);
        check_val("combo", int'(combo), got.cb);
        check_val("max_combo", int'(max_combo), got.mx);
        strike = 4'd0; note_arrive = 4'd0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        do_reset();

        // Note then strike one cycle later: PERFECT, score 3, combo 1.
        step(4'd0, 4'b0001, 1'b0);
        step(4'b0001, 4'd0, 1'b0);
        idle(1);
        check_val("t1_score", int'(score), 3);
        check_val("t1_combo", int'(combo), 1);

        // Unstruck note on lane 1 expires.
        step(4'd0, 4'b0010, 1'b0);
        idle(10);

        // Build combo 5, then a stray strike on lane 2.
        for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001, 1'b0);
        step(4'b0100, 4'd0, 1'b0);
        idle(1);
        check_val("t3_combo", int'(combo), 0);
        check_val("t3_max_combo", int'(max_combo), 5);

        // Lane 0 PERFECT + lane 3 GOOD together; then the same with a lane 1 stray.
        step(4'd0, 4'b1000, 1'b0);
        step(4'd0, 4'b0001, 1'b0);
        step(4'b1001, 4'd0, 1'b0);
        step(4'd0, 4'b1000, 1'b0);
        step(4'd0, 4'b0001, 1'b0);
        step(4'b1011, 4'd0, 1'b0);
        idle(2);

        // Displaced note, strike with a new arrival, strike on the last window count.
        step(4'd0, 4'b0100, 1'b0);
        step(4'd0, 4'b0100, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        idle(6);
        step(4'b0100, 4'd0, 1'b0);
        step(4'd0, 4'b0100, 1'b0);
        idle(7);
        step(4'b0100, 4'd0, 1'b0);

        // Clear while a hit is being accumulated.
        step(4'b0001, 4'b0001, 1'b0);
        step(4'd0, 4'd0, 1'b1);
        idle(1);
        check_val("clear_score", int'(score), 0);

        // Eleven consecutive PERFECTs from zero: small score saturates, last one may get bonus.
        step(4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 11; i++) step(4'b0001, 4'b0001, 1'b0);
        idle(1);
        check_val("t5_small_sat", int'(score_b), 15);
        check_val("t6_combo", int'(combo), 11);
`ifdef HIT_SCORER_COMBO_BONUS_EN
        check_val("t6_bonus_score", int'(score), 36);
`else
        check_val("t6_plain_score", int'(score), 33);
`endif
        step(4'd0, 4'd0, 1'b1);
        check_val("t5_clear_small", int'(score_b), 0);

        // Reset with a window open must not produce a miss afterwards.
        step(4'd0, 4'b0010, 1'b0);
        idle(3);
        do_reset();
        idle(10);

        // Random pulses across all lanes.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] st, ar;
            for (int l = 0; l < LANES; l++) begin
                st[l] = ($urandom_range(0, 4) == 0);
                ar[l] = ($urandom_range(0, 5) == 0);
            end
            step(st, ar, ($urandom_range(0, 60) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
